// File: rtl/led_pattern_driver.sv
// LED pattern driver: static/blink/chase/lamp-test patterns with 16-level PWM dimming,
// decoded from a registered PIO control word.
module led_pattern_driver #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ctrl_word,
  output logic [7:0]  led_out,
  output logic        step_pulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_CHASE  = 2'b10;
  localparam logic [1:0] MODE_LAMP   = 2'b11;

  logic [31:0]   ctrl_q;
  logic [PW-1:0] presc;
  logic [7:0]    step_cnt;
  logic [3:0]    pwm_cnt;
  logic          blink_phase;
  logic [7:0]    chase_pos;

  logic [7:0] mask;
  logic [3:0] duty;
  logic [1:0] mode;
  logic [7:0] rate;
  logic       enable;

  logic       restart;
  logic       base_tick;
  logic       step;
  logic       pwm_on;
  logic [7:0] led_next;

  assign mask   = ctrl_q[7:0];
  assign duty   = ctrl_q[11:8];
  assign mode   = ctrl_q[13:12];
  assign rate   = ctrl_q[23:16];
  assign enable = ctrl_q[31];

  // Any change of the incoming word (including ignored bits) restarts the pattern.
  assign restart   = (ctrl_word != ctrl_q);
  assign base_tick = !restart && (presc == PW'(PRESCALE - 1));
  assign step      = base_tick && (step_cnt >= rate);
  assign pwm_on    = (pwm_cnt <= duty);

  always_comb begin
    led_next = 8'h00;
    if (enable) begin
      case (mode)
        MODE_STATIC: led_next = mask & {8{pwm_on}};
        MODE_BLINK:  led_next = mask & {8{pwm_on & blink_phase}};
        MODE_CHASE:  led_next = mask & chase_pos & {8{pwm_on}};
        MODE_LAMP:   led_next = 8'hFF;
        default:     led_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= 32'h0;
      presc       <= '0;
      step_cnt    <= 8'h00;
      pwm_cnt     <= 4'h0;
      blink_phase <= 1'b1;
      chase_pos   <= 8'h01;
      step_pulse  <= 1'b0;
      led_out     <= 8'h00;
    end else begin
      ctrl_q     <= ctrl_word;
      pwm_cnt    <= pwm_cnt + 4'd1;
      step_pulse <= step;
      led_out    <= led_next;
      if (restart) begin
        presc       <= '0;
        step_cnt    <= 8'h00;
        blink_phase <= 1'b1;
        chase_pos   <= 8'h01;
      end else begin
        presc <= base_tick ? '0 : presc + PW'(1);
        if (base_tick) begin
          step_cnt <= step ? 8'h00 : step_cnt + 8'd1;
        end
        if (step && (mode == MODE_BLINK)) begin
          blink_phase <= ~blink_phase;
        end
        if (step && (mode == MODE_CHASE)) begin
          chase_pos <= {chase_pos[6:0], chase_pos[7]};
        end
      end
    end
  end

endmodule

// File: doc/led_pattern_driver.md
LED_PATTERN_DRIVER -- requirements
Module: led_pattern_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per base tick (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ctrl_word  input  32  control word from the LED PIO output register, same clock domain, no synchronizer.
REQ-005 SHALL have port led_out  output  8  registered LED drive, 1 = lit.
REQ-006 SHALL have port step_pulse  output  1  registered one-clk pulse on every pattern step.

Function
REQ-007 SHALL decode ctrl_word fields as follows:
- [7:0] mask
- [11:8] duty
- [13:12] mode (00 static, 01 blink, 10 chase, 11 lamp test)
- [23:16] rate
- [31] enable
- all other bits ignored.
REQ-008 SHALL register ctrl_word into ctrl_q every clk; all decoding uses ctrl_q.
REQ-009 SHALL assert an internal restart for exactly one clk when ctrl_word != ctrl_q.
REQ-010 SHALL run a prescaler counting 0..PRESCALE-1 and emit base_tick when it wraps from PRESCALE-1 to 0.
REQ-011 SHALL run a step counter counting 0..rate on base_tick and emit step when it wraps from rate to 0; rate=0 gives one step per base tick.
REQ-012 SHALL run a free-running 4-bit pwm_cnt incrementing every clk, 15 wrapping to 0, and never restarted by restart.
REQ-013 SHALL set pwm_on = (pwm_cnt <= duty), giving duty 0 = 1/16 on-time and duty 15 = always on.
REQ-014 SHALL, in blink mode, toggle blink_phase on each step; LEDs are lit only while blink_phase = 1.
REQ-015 SHALL, in chase mode, hold an 8-bit one-hot chase_pos that rotates left on each step (bit7 wraps to bit0).
REQ-016 SHALL compute the next led_out value per mode:
- static: mask & {8{pwm_on}}
- blink: mask & {8{pwm_on & blink_phase}}
- chase: mask & chase_pos & {8{pwm_on}}
- lamp test: 8'hFF, ignoring mask, duty and pwm.
REQ-017 SHALL force led_out to 8'h00 whenever enable = 0, overriding all modes including lamp test.
REQ-018 SHALL, on restart, have the following values on the next clk, and restart SHALL take priority over a coincident base_tick or step:
- prescaler = 0
- step counter = 0
- blink_phase = 1
- chase_pos = 8'h01.
REQ-019 SHALL keep the prescaler and step counter running in every mode, including when enable = 0, so step_pulse continues.
REQ-020 SHALL register led_out, so a ctrl_word change first affects led_out 2 clks after it is presented.
REQ-021 SHALL assert step_pulse on the clk after the internal step, for exactly one clk.
REQ-022 SHALL, if a chase step occurs while mask bit at chase_pos is 0, leave that step dark; positions are never skipped.

Reset
REQ-023 SHALL, while reset_n = 0, asynchronously clear all state:
- led_out = 0, step_pulse = 0
- ctrl_q = 0, prescaler = 0, step counter = 0, pwm_cnt = 0
- blink_phase = 1, chase_pos = 8'h01.
REQ-024 SHALL treat the first post-reset clk with ctrl_word != 0 as a restart; the PIO reset value 32'hFFFFFFFF therefore yields lamp test (led_out = 8'hFF) 2 clks after reset release.
REQ-025 SHALL, if reset is asserted mid-pattern, drive led_out to 0 immediately and resume from the REQ-023 state on release.

Verification (PRESCALE=4)
REQ-026 SHALL verify reset: release reset with ctrl_word = 32'hFFFFFFFF -> led_out = 8'hFF 2 clks after release and held constant.
REQ-027 SHALL verify static PWM: ctrl_word = 32'h8000_03A5 -> led_out = 8'hA5 for 4 of every 16 clks and 8'h00 otherwise; duty 4'hF -> constant 8'hA5.
REQ-028 SHALL verify blink: ctrl_word = 32'h8001_1F0F -> step_pulse every 8 clks, led_out alternating 8'h0F and 8'h00 per step, starting lit.
REQ-029 SHALL verify chase wrap: ctrl_word = 32'h8000_2FFF -> led_out walks 01,02,...,80,01 with one position per 4-clk step.
REQ-030 SHALL verify disable and restart priority:
- enable = 0 with mode 11 -> led_out = 8'h00.
- ctrl_word change on a step boundary -> chase restarts at 8'h01 and no rotation occurs on that clk.
